// File: rtl/rob_commit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_commit_pkg / rob_commit                                              |
// | In-order reorder buffer: allocate, track completion, retire in order,    |
// | and squash younger entries on a branch mispredict.                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rob_commit_pkg;
  localparam int PREG_IDX_W = 6;

  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] idx;
  } p_reg_t;

  typedef struct packed {
    logic   valid;
    p_reg_t rd;
  } rinstr_t;

  typedef struct packed {
    logic valid;
    logic hit;
  } br_result_t;
endpackage

module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TAG_W   = $clog2(DEPTH),
  parameter int P_IDX_W = PREG_IDX_W
) (
  input  logic             clk,
  input  logic             rst_i,
  input  rinstr_t          rinstr_i,
  input  logic             is_branch_i,
  output logic [TAG_W-1:0] alloc_tag_o,
  output logic             rob_full_o,
  output logic             rob_empty_o,
  input  logic             wb_valid_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  br_result_t       br_result_i,
  output p_reg_t           p_commit_o,
  output logic             flush_o
);

  localparam logic [TAG_W:0]   c_full    = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W-1:0] c_tag_one = TAG_W'(1);
  localparam logic [TAG_W:0]   c_cnt_one = (TAG_W+1)'(1);

  logic [DEPTH-1:0]   r_occ;
  logic [DEPTH-1:0]   r_done;
  logic [DEPTH-1:0]   r_rd_v;
  logic [P_IDX_W-1:0] r_rd_idx [DEPTH];
  logic [TAG_W-1:0]   r_head;
  logic [TAG_W-1:0]   r_tail;
  logic [TAG_W:0]     r_count;
  logic               r_br_pend;
  logic [TAG_W-1:0]   r_br_tag;
  p_reg_t             r_commit;
  logic               r_flush;

  logic               w_full;
  logic               w_retire;
  logic               w_resolve;
  logic               w_mispredict;
  logic               w_alloc;
  logic [TAG_W-1:0]   w_br_off;
  logic [DEPTH-1:0]   w_young;

  assign w_full       = (r_count == c_full);
  assign w_retire     = r_occ[r_head] && r_done[r_head];
  assign w_resolve    = br_result_i.valid && r_br_pend;
  assign w_mispredict = w_resolve && !br_result_i.hit;
  // A squash overrides any same-cycle allocation.
  assign w_alloc      = rinstr_i.valid && !w_full && !w_mispredict;
  assign w_br_off     = r_br_tag - r_head;

  // Age is measured as distance from head, so a full buffer is handled too.
  for (genvar g = 0; g < DEPTH; g++) begin : g_young
    localparam logic [TAG_W-1:0] c_idx = TAG_W'(g);
    logic [TAG_W-1:0] w_off;
    assign w_off      = c_idx - r_head;
    assign w_young[g] = (w_off > w_br_off);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_occ  <= '0;
      r_done <= '0;
      r_rd_v <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd_idx[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc && (r_tail == TAG_W'(i))) begin
          r_occ[i]    <= 1'b1;
          r_done[i]   <= 1'b0;
          r_rd_v[i]   <= rinstr_i.rd.valid && (rinstr_i.rd.idx != '0);
          r_rd_idx[i] <= P_IDX_W'(rinstr_i.rd.idx);
        end else begin
          if ((w_mispredict && w_young[i]) ||
              (w_retire && (r_head == TAG_W'(i)))) begin
            r_occ[i] <= 1'b0;
          end
          if ((wb_valid_i && (wb_tag_i == TAG_W'(i)) && r_occ[i]) ||
              (w_resolve && (r_br_tag == TAG_W'(i)))) begin
            r_done[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_br_pend <= 1'b0;
      r_br_tag  <= '0;
      r_commit  <= '0;
      r_flush   <= 1'b0;
    end else begin
      if (w_retire) begin
        r_head <= r_head + c_tag_one;
      end
      if (w_mispredict) begin
        r_tail  <= r_br_tag + c_tag_one;
        r_count <= {1'b0, w_br_off} + c_cnt_one - (TAG_W+1)'(w_retire);
      end else begin
        r_tail  <= r_tail + TAG_W'(w_alloc);
        r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
      end
      if (w_resolve) begin
        r_br_pend <= 1'b0;
      end
      if (w_alloc && is_branch_i) begin
        r_br_pend <= 1'b1;
        r_br_tag  <= r_tail;
      end
      r_commit.valid <= w_retire && r_rd_v[r_head];
      r_commit.idx   <= (w_retire && r_rd_v[r_head]) ? PREG_IDX_W'(r_rd_idx[r_head]) : '0;
      r_flush        <= w_mispredict;
    end
  end

  assign alloc_tag_o = r_tail;
  assign rob_full_o  = w_full;
  assign rob_empty_o = (r_count == '0);
  assign p_commit_o  = r_commit;
  assign flush_o     = r_flush;

endmodule
`default_nettype wire
